// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - sequential RV32I ALU with iterative mul/mulhu and optional divu/remu (ALU_SEQ_DIV_EN)
module alu_seq_muldiv #(
    parameter int XLEN               = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] ina,
    input  logic [XLEN-1:0] inb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            zero,
    output logic            err
);

    localparam int SHW       = $clog2(XLEN);
    localparam int CW        = $clog2(XLEN) + 1;
    localparam int PW        = 2 * XLEN;
    localparam int MUL_STEPS = XLEN / MUL_BITS_PER_CYCLE;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    // EXEC is the single compute cycle of simple/illegal ops.
    typedef enum logic [1:0] {IDLE, EXEC, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [3:0]      op_q, op_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] out_q, out_d;
    logic            zero_q, zero_d;
    logic            err_q, err_d;
    logic            out_valid_q, out_valid_d;

    logic [XLEN-1:0] simple_res;
    logic            simple_err;
    logic [SHW-1:0]  shamt;
    logic [XLEN+1:0] pp;
    logic [XLEN+1:0] mul_sum;
    logic [PW-1:0]   mul_next;
    logic [PW-1:0]   step_next;
    logic [CW-1:0]   last_cnt;
    logic [XLEN-1:0] iter_res;
    logic            acc_div;
    logic            acc_multi;
    logic            cur_div;

`ifdef ALU_SEQ_DIV_EN
    logic [XLEN:0]   r_sh;
    logic [XLEN:0]   diff;
    logic [PW-1:0]   div_next;
`endif

    assign shamt     = b_q[SHW-1:0];
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign zero      = zero_q;
    assign err       = err_q;

    // Single-cycle integer ops on the captured operands; unknown codes flag err.
    always_comb begin
        simple_res = '0;
        simple_err = 1'b0;
        case (op_q)
            OP_ADD:  simple_res = a_q + b_q;
            OP_SUB:  simple_res = a_q - b_q;
            OP_AND:  simple_res = a_q & b_q;
            OP_OR:   simple_res = a_q | b_q;
            OP_XOR:  simple_res = a_q ^ b_q;
            OP_SLL:  simple_res = a_q << shamt;
            OP_SRL:  simple_res = a_q >> shamt;
            OP_SRA:  simple_res = $signed(a_q) >>> shamt;
            OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
            default: simple_err = 1'b1;
        endcase
    end

    // Shift-add multiply step: add multiplicand times the low multiplier bits, then shift right.
    always_comb begin
        pp = '0;
        for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
            if (prod_q[i]) begin
                pp = pp + ({2'b00, a_q} << i);
            end
        end
        mul_sum  = {2'b00, prod_q[PW-1:XLEN]} + pp;
        mul_next = PW'({mul_sum, prod_q[XLEN-1:0]} >> MUL_BITS_PER_CYCLE);
    end

`ifdef ALU_SEQ_DIV_EN
    // Restoring divide step: remainder in the upper half, dividend/quotient in the lower half.
    always_comb begin
        r_sh = {prod_q[PW-1:XLEN], prod_q[XLEN-1]};
        diff = r_sh - {1'b0, b_q};
        if (diff[XLEN]) begin
            div_next = {r_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        end
    end

    assign acc_div   = (alu_op == OP_DIVU) || (alu_op == OP_REMU);
    assign cur_div   = (op_q == OP_DIVU) || (op_q == OP_REMU);
    assign step_next = cur_div ? div_next : mul_next;
    assign last_cnt  = cur_div ? CW'(XLEN - 1) : CW'(MUL_STEPS - 1);
`else
    assign acc_div   = 1'b0;
    assign cur_div   = 1'b0;
    assign step_next = mul_next;
    assign last_cnt  = CW'(MUL_STEPS - 1);
`endif

    assign acc_multi = (alu_op == OP_MUL) || (alu_op == OP_MULHU) || acc_div;
    // mulhu/remu (opcode bit 0 set) take the upper half, mul/divu the lower half.
    assign iter_res  = op_q[0] ? step_next[PW-1:XLEN] : step_next[XLEN-1:0];

    // Next-state and datapath updates for the IDLE/EXEC/BUSY/DONE sequence.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        zero_d      = zero_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = ina;
                    b_d     = inb;
                    op_d    = alu_op;
                    cnt_d   = '0;
                    prod_d  = {{XLEN{1'b0}}, (acc_div ? ina : inb)};
                    state_d = acc_multi ? BUSY : EXEC;
                end
            end
            EXEC: begin
                out_d       = simple_res;
                zero_d      = (simple_res == '0);
                err_d       = simple_err;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            BUSY: begin
                prod_d = step_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == last_cnt) begin
                    out_d       = iter_res;
                    zero_d      = (iter_res == '0);
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
